ram_access_sequencer: RTL and testbench
=======================================

// Module: ram_access_sequencer
// PURPOSE
//  Sits directly upstream of the byte-wide synchronous RAM and feeds it.
//  - Accepts one 8/16/32-bit load/store request from the CPU load/store path.
//  - Splits the request into sequential little-endian byte accesses on the RAM port.
//  - Assembles load data, sign- or zero-extends it, and reports completion/error.
// PARAMETERS
//  RAM_SIZE  4096  RAM depth in bytes; byte addresses >= RAM_SIZE are illegal
// PORTS
//  clk              in   1   single clock; all state on posedge
//  rst_n            in   1   asynchronous, active-low reset
//  start            in   1   request strobe; accepted only when busy=0
//  write            in   1   1=store, 0=load (sampled at accept)
//  width            in   2   00=byte, 01=half, 10=word, 11=illegal
//  load_signed      in   1   1=sign-extend byte/half loads, 0=zero-extend
//  address          in   32  byte address of lowest byte; misalignment allowed
//  write_data       in   32  store data; bytes [8i+7:8i] go to address+i
//  busy             out  1   high from accept edge through the done cycle
//  done             out  1   one-cycle completion pulse
//  error            out  1   valid with done; 1 = request rejected, no RAM access
//  read_data        out  32  load result; updated only on a successful load's done
//  mem_address      out  32  to RAM address
//  mem_write_data   out  8   to RAM write_data
//  mem_write_enable out  1   to RAM write_enable
//  mem_read_data    in   8   from RAM read_data; 1-cycle latency after address
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - State IDLE; all outputs 0; internal latches cleared.
//   - A mid-operation reset aborts immediately; mem_write_enable drops asynchronously.
//   - Bytes already written stay in RAM.
//  N = 1/2/4 for width 00/01/10.
//  FSM IDLE -> (XFER | DONE) ; XFER -> (DRAIN | DONE) ; DRAIN -> DONE ; DONE -> IDLE
//  IDLE: on start, latch write/width/load_signed/address/write_data; busy=1 next cycle.
//   - Error if width=11, or {1'b0,address}+N-1 >= RAM_SIZE (33-bit compare; 32-bit wrap is illegal).
//   - On error go to DONE with error=1: no RAM access, read_data unchanged.
//   - Otherwise go to XFER with byte counter i=0.
//  XFER, one byte per cycle, i=0..N-1:
//   - mem_address = address+i.
//   - Store: mem_write_enable=1, mem_write_data=write_data[8i+7:8i].
//   - Load: mem_write_enable=0; for i>=1, capture mem_read_data into byte i-1.
//   - After i=N-1: store -> DONE, load -> DRAIN.
//  DRAIN (load only): mem_write_enable=0; capture mem_read_data into byte N-1.
//  DONE: done=1 for exactly one cycle, busy=1, error valid.
//   - On a successful load, read_data = extended result from this cycle on.
//   - read_data is held until the next successful load.
//  Latency, accept edge to done cycle: store N+1 cycles; load N+2 cycles; error 1 cycle.
//  - start while busy=1 (including the DONE cycle) is ignored, not queued.
//  - mem_address holds its last value outside XFER/DRAIN; mem_write_data=0 unless storing.
//  - mem_write_enable is never high in IDLE, DRAIN or DONE.
//  - Extension: byte -> bit7 or 0 into [31:8]; half -> bit15 or 0 into [31:16]; word unchanged.
// TESTING
//  1. Store word 0xDEADBEEF @0x10 -> WE 4 cycles; addr 0x10..0x13 data EF,BE,AD,DE; done 5 cycles after accept, error=0.
//  2. Load after 1: word @0x10 -> read_data=0xDEADBEEF at done, 6 cycles after accept; half signed @0x12 -> 0xFFFFDEAD.
//  3. Half unsigned @0x11 (misaligned) after 1 -> read_data=0x0000ADBE; byte signed @0x13 -> 0xFFFFFFDE.
//  4. Word @RAM_SIZE-2 or width=11 -> done+error next cycle, mem_write_enable never high, read_data unchanged.
//  5. Assert start again during busy -> ignored. rst_n low mid-store after 2 bytes -> outputs 0 immediately; later load shows only bytes 0-1 written.

Source files
------------

// File: rtl/ram_access_sequencer.sv
// ram_access_sequencer: splits one 8/16/32-bit load/store into little-endian byte accesses on a byte-wide synchronous RAM
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             request strobe, accepted only while busy=0
//   write             1=store, 0=load
//   width             00=byte, 01=half, 10=word, 11=illegal
//   load_signed       sign-extend byte/half loads when set
//   address           byte address of the lowest byte (misalignment allowed)
//   write_data        store data, byte i goes to address+i
//   busy              high from the accept edge through the done cycle
//   done              one-cycle completion pulse
//   error             qualified by done; request rejected without RAM access
//   read_data         extended load result, updated on a successful load's done
//   mem_address       RAM byte address
//   mem_write_data    RAM write byte
//   mem_write_enable  RAM write strobe
//   mem_read_data     RAM read byte, one cycle after its address
module ram_access_sequencer #(
    parameter int RAM_SIZE = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        write,
    input  logic [1:0]  width,
    input  logic        load_signed,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] read_data,
    output logic [31:0] mem_address,
    output logic [7:0]  mem_write_data,
    output logic        mem_write_enable,
    input  logic [7:0]  mem_read_data
);

    typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic [1:0]  width_q, width_d;
    logic        signed_q, signed_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] read_data_q, read_data_d;
    logic [31:0] mem_addr_q, mem_addr_d;

    logic [1:0]  req_last;
    logic [1:0]  last;
    logic [32:0] req_end;
    logic        req_bad;
    logic        cap;
    logic [1:0]  cap_idx;
    logic [31:0] wr_shift;

    // Offset of the final byte: 0/1/3 for byte/half/word
    assign req_last = (width == 2'b00) ? 2'd0 : (width == 2'b01) ? 2'd1 : 2'd3;
    assign last     = (width_q == 2'b00) ? 2'd0 : (width_q == 2'b01) ? 2'd1 : 2'd3;
    // 33-bit sum so a request wrapping past 2^32 is caught as out of range
    assign req_end  = {1'b0, address} + {31'd0, req_last};
    assign req_bad  = (width == 2'b11) || (req_end >= 33'(RAM_SIZE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            width_q     <= 2'b00;
            signed_q    <= 1'b0;
            wdata_q     <= 32'd0;
            cnt_q       <= 2'd0;
            err_q       <= 1'b0;
            asm_q       <= 32'd0;
            read_data_q <= 32'd0;
            mem_addr_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            width_q     <= width_d;
            signed_q    <= signed_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            asm_q       <= asm_d;
            read_data_q <= read_data_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        width_d     = width_q;
        signed_d    = signed_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        asm_d       = asm_q;
        read_data_d = read_data_q;
        mem_addr_d  = mem_addr_q;
        // The RAM returns the byte addressed in the previous cycle, so loads
        // capture byte i-1 during XFER step i and the last byte in DRAIN
        cap         = !wr_q && ((state_q == XFER && cnt_q != 2'd0) || state_q == DRAIN);
        cap_idx     = (state_q == DRAIN) ? last : cnt_q - 2'd1;
        for (int k = 0; k < 4; k++) begin
            if (cap && cap_idx == 2'(k)) asm_d[8*k +: 8] = mem_read_data;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    wr_d     = write;
                    width_d  = width;
                    signed_d = load_signed;
                    wdata_d  = write_data;
                    cnt_d    = 2'd0;
                    asm_d    = 32'd0;
                    err_d    = req_bad;
                    state_d  = req_bad ? DONE : XFER;
                    if (!req_bad) mem_addr_d = address;
                end
            end
            XFER: begin
                if (cnt_q == last) begin
                    state_d = wr_q ? DONE : DRAIN;
                end else begin
                    cnt_d      = cnt_q + 2'd1;
                    mem_addr_d = mem_addr_q + 32'd1;
                end
            end
            DRAIN: begin
                state_d     = DONE;
                read_data_d = (width_q == 2'b00) ? {{24{signed_q & asm_d[7]}}, asm_d[7:0]} :
                              (width_q == 2'b01) ? {{16{signed_q & asm_d[15]}}, asm_d[15:0]} :
                              asm_d;
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_shift = wdata_q >> {cnt_q, 3'b000};

    always_comb begin
        busy             = state_q != IDLE;
        done             = state_q == DONE;
        error            = done && err_q;
        read_data        = read_data_q;
        mem_address      = mem_addr_q;
        mem_write_enable = state_q == XFER && wr_q;
        mem_write_data   = mem_write_enable ? wr_shift[7:0] : 8'd0;
    end

endmodule

// File: tb/tb_ram_access_sequencer.sv
// tb_ram_access_sequencer: directed self-checking bench with a byte RAM model
module tb_ram_access_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        write = 1'b0;
    logic [1:0]  width = 2'b00;
    logic        load_signed = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic        busy, done, error;
    logic [31:0] read_data, mem_address;
    logic [7:0]  mem_write_data;
    logic        mem_write_enable;
    logic [7:0]  mem_read_data;

    logic [7:0]  ram [0:4095];
    logic [31:0] log_a [0:7];
    logic [7:0]  log_d [0:7];
    int checks = 0;
    int errors = 0;
    int lat, we_cnt, err_seen, we_bad;

    always #5 clk = ~clk;

    ram_access_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .write(write), .width(width),
        .load_signed(load_signed), .address(address), .write_data(write_data),
        .busy(busy), .done(done), .error(error), .read_data(read_data),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
    );

    initial for (int i = 0; i < 4096; i++) ram[i] = 8'd0;

    always @(posedge clk) begin
        if (mem_write_enable) ram[mem_address[11:0]] <= mem_write_data;
        mem_read_data <= ram[mem_address[11:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request and follows it to done. With pester set, start is
    // held high with a conflicting store for the whole busy period.
    task automatic run(input logic w, input logic [1:0] wd, input logic s,
                       input logic [31:0] a, input logic [31:0] d, input logic pester);
        @(negedge clk);
        start = 1'b1; write = w; width = wd; load_signed = s; address = a; write_data = d;
        @(posedge clk);
        @(negedge clk);
        if (pester) begin
            write = 1'b1; width = 2'b00; address = 32'h20; write_data = 32'hA5;
        end else start = 1'b0;
        lat = 1; we_cnt = 0; we_bad = 0;
        while (!done && lat < 20) begin
            if (mem_write_enable) begin
                log_a[we_cnt[2:0]] = mem_address;
                log_d[we_cnt[2:0]] = mem_write_data;
                we_cnt++;
            end
            @(negedge clk);
            lat++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        if (mem_write_enable) we_bad = 1;
        err_seen = {31'd0, error};
        if (pester) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] rd_prev;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rd", read_data, 32'd0);
        check("rst_addr", mem_address, 32'd0);
        check("rst_we", {31'd0, mem_write_enable}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        check("st_lat", lat, 5);
        check("st_we_cnt", we_cnt, 4);
        check("st_err", err_seen, 0);
        check("st_we_done", we_bad, 0);
        check("st_a0", log_a[0], 32'h10);
        check("st_a3", log_a[3], 32'h13);
        check("st_d0", {24'd0, log_d[0]}, 32'hEF);
        check("st_d1", {24'd0, log_d[1]}, 32'hBE);
        check("st_d2", {24'd0, log_d[2]}, 32'hAD);
        check("st_d3", {24'd0, log_d[3]}, 32'hDE);

        run(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0);
        check("ldw_lat", lat, 6);
        check("ldw_we", we_cnt, 0);
        check("ldw_rd", read_data, 32'hDEADBEEF);
        run(1'b0, 2'b01, 1'b1, 32'h12, 32'd0, 1'b0);
        check("ldh_s_lat", lat, 4);
        check("ldh_s_rd", read_data, 32'hFFFFDEAD);
        run(1'b0, 2'b01, 1'b0, 32'h11, 32'd0, 1'b0);
        check("ldh_u_rd", read_data, 32'h0000ADBE);
        run(1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 1'b0);
        check("ldb_s_lat", lat, 3);
        check("ldb_s_rd", read_data, 32'hFFFFFFDE);
        run(1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 1'b0);
        check("ldb_u_rd", read_data, 32'h000000DE);

        rd_prev = read_data;
        run(1'b1, 2'b10, 1'b0, 32'd4094, 32'h12345678, 1'b0);
        check("oor_lat", lat, 1);
        check("oor_err", err_seen, 1);
        check("oor_we", we_cnt, 0);
        check("oor_rd", read_data, rd_prev);
        run(1'b0, 2'b11, 1'b0, 32'h10, 32'd0, 1'b0);
        check("w11_err", err_seen, 1);
        check("w11_rd", read_data, rd_prev);
        run(1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0);
        check("wrap_err", err_seen, 1);
        check("wrap_lat", lat, 1);

        run(1'b1, 2'b00, 1'b0, 32'd4095, 32'h0000005A, 1'b0);
        check("top_st_err", err_seen, 0);
        check("top_st_lat", lat, 2);
        run(1'b0, 2'b00, 1'b1, 32'd4095, 32'd0, 1'b0);
        check("top_ld_rd", read_data, 32'h0000005A);
        run(1'b0, 2'b10, 1'b0, 32'd4092, 32'd0, 1'b0);
        check("top_ldw_err", err_seen, 0);
        check("top_ldw_rd", read_data, 32'h5A000000);

        run(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b1);
        check("pest_rd", read_data, 32'hDEADBEEF);
        check("pest_lat", lat, 6);
        @(negedge clk);
        check("pest_idle", {31'd0, busy}, 32'd0);
        check("pest_ram", {24'd0, ram[32'h20]}, 32'd0);

        @(negedge clk);
        start = 1'b1; write = 1'b1; width = 2'b10; address = 32'h40; write_data = 32'h11223344;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_we", {31'd0, mem_write_enable}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_we", {31'd0, mem_write_enable}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_addr", mem_address, 32'd0);
        check("mid_rst_rd", read_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 1'b0);
        check("mid_ld_rd", read_data, 32'h00003344);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
